// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel UART receive stage.
// Synchronises rx line, samples mid-bit, checks stop bit.
// Ports:
//   i_clk, i_rst      clock, sync active-high reset
//   i_rx_serial       async serial line, idle high
//   o_rx_dv           1-cycle strobe, o_rx_byte valid
//   o_rx_byte         last good byte, held
//   o_rx_busy         frame in progress
//   o_frame_err       1-cycle strobe, stop bit low
//   o_parity_err      1-cycle strobe with o_rx_dv
// Optional: UART_RX_PARITY_EN adds one even-parity bit.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 87,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
    $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rx_byte, byte_n;
  logic          dv, dv_n;
  logic          ferr, ferr_n;
  logic          rx_meta, rx_sync;
  logic          mid, full;
  logic [7:0]    shift_in;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx_sync <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pbad, pbad_n;
  logic perr, perr_n;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      rx_byte <= '0;
      dv      <= 1'b0;
      ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad    <= 1'b0;
      perr    <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      rx_byte <= byte_n;
      dv      <= dv_n;
      ferr    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      pbad    <= pbad_n;
      perr    <= perr_n;
`endif
    end
  end

  assign mid  = (cnt == HALF);
  assign full = (cnt == FULL);
  assign shift_in = MSB_FIRST ?
    {shift[6:0], rx_sync} :
    {rx_sync, shift[7:1]};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    byte_n  = rx_byte;
    dv_n    = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_n  = pbad;
    perr_n  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (mid) begin
          cnt_n = '0;
          idx_n = '0;
          // still low at mid-start: real start bit
          state_n = rx_sync ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (full) begin
          cnt_n   = '0;
          shift_n = shift_in;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (full) begin
          cnt_n   = '0;
          state_n = STOP;
`ifdef UART_RX_PARITY_EN
          pbad_n  = rx_sync ^ (^shift);
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        // leave at mid-stop so a following
        // start bit is not missed
        if (full) begin
          cnt_n = '0;
          if (rx_sync) begin
            byte_n  = shift;
            dv_n    = 1'b1;
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_n  = pbad;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_rx_dv     = dv;
  assign o_rx_byte   = rx_byte;
  assign o_rx_busy   = (state != IDLE);
  assign o_frame_err = ferr;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames, scoreboard
// queue checked by a pulse monitor.
module tb_uart_receiver;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit MSBF = 1'b0;
  localparam int LAT  = 87;
`else
  localparam bit MSBF = 1'b1;
  localparam int LAT  = 79;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rxs;
  logic       dv;
  logic [7:0] rbyte;
  logic       busy;
  logic       ferr;
  logic       perr;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .MSB_FIRST(MSBF)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_serial(rxs),
    .o_rx_dv(dv),
    .o_rx_byte(rbyte),
    .o_rx_busy(busy),
    .o_frame_err(ferr),
    .o_parity_err(perr)
  );

  typedef struct {
    logic       isdv;
    logic [7:0] b;
    logic       pe;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] last;
`ifdef UART_RX_PARITY_EN
  logic flip = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (dv || ferr) begin
      chk("dv_ferr_excl", {31'd0, dv & ferr}, 0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got dv=%0b ferr=%0b want none",
                 dv, ferr);
      end else begin
        me = q.pop_front();
        chk("dv", {31'd0, dv}, {31'd0, me.isdv});
        chk("ferr", {31'd0, ferr}, {31'd0, !me.isdv});
        chk("byte", {24'd0, rbyte}, {24'd0, me.b});
        chk("perr", {31'd0, perr}, {31'd0, me.pe});
        chk("latency", cyc, me.at);
      end
    end
  end

  task automatic drive(input logic b, input int n);
    rxs = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic stp);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++)
      drive(MSBF ? d[7-i] : d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ flip, CPB);
`endif
    drive(stp, CPB);
  endtask

  task automatic expect_ev(input logic isdv,
                           input logic [7:0] b,
                           input logic pe);
    exp_t e;
    e.isdv = isdv;
    e.b    = b;
    e.pe   = pe;
    e.at   = cyc + LAT;
    q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d5;
    bit seen;
    int dropped;
    rst = 1'b1;
    rxs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", {31'd0, dv}, 0);
    chk("rst_byte", {24'd0, rbyte}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ferr", {31'd0, ferr}, 0);
    chk("rst_perr", {31'd0, perr}, 0);
    rst = 1'b0;
    drive(1'b1, 10);

    // 1: single byte
    expect_ev(1'b1, 8'hA5, 1'b0);
    send(8'hA5, 1'b1);
    last = 8'hA5;
    drive(1'b1, 16);

    // 2: short glitch rejected
    drive(1'b0, 2);
    rxs = 1'b1;
    seen = 0;
    dropped = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
      else if (seen && dropped < 0) dropped = i;
    end
    chk("glitch_busy_seen", {31'd0, seen}, 1);
    chk("glitch_busy_drop",
        {31'd0, (dropped >= 0 && dropped <= 6)}, 1);
    @(posedge clk);
    #1;
    drive(1'b1, 8);

    // 3: framing error, line held low
    expect_ev(1'b0, last, 1'b0);
    send(8'h3C, 1'b0);
    drive(1'b0, 40);
    drive(1'b1, 16);
    chk("ferr_byte_held", {24'd0, rbyte}, {24'd0, last});
    expect_ev(1'b1, 8'h11, 1'b0);
    send(8'h11, 1'b1);
    last = 8'h11;
    drive(1'b1, 12);

    // 4: back-to-back, no idle gap
    expect_ev(1'b1, 8'h00, 1'b0);
    send(8'h00, 1'b1);
    expect_ev(1'b1, 8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    drive(1'b1, 12);

    // 5: reset during data bit 4
    d5 = 8'h5A;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++)
      drive(MSBF ? d5[7-i] : d5[i], CPB);
    drive(MSBF ? d5[3] : d5[4], 4);
    rst = 1'b1;
    drive(1'b1, 1);
    chk("mrst_dv", {31'd0, dv}, 0);
    chk("mrst_byte", {24'd0, rbyte}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_ferr", {31'd0, ferr}, 0);
    rst = 1'b0;
    drive(1'b1, 20);
    chk("mrst_idle", {31'd0, busy}, 0);
    expect_ev(1'b1, 8'hC3, 1'b0);
    send(8'hC3, 1'b1);
    drive(1'b1, 12);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    flip = 1'b0;
    expect_ev(1'b1, 8'h01, 1'b0);
    send(8'h01, 1'b1);
    drive(1'b1, 8);
    flip = 1'b1;
    expect_ev(1'b1, 8'h01, 1'b1);
    send(8'h01, 1'b1);
    flip = 1'b0;
    drive(1'b1, 12);
`endif

    for (int i = 0; i < 300 && q.size() > 0; i++)
      @(posedge clk);
    chk("queue_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
